// File: rtl/mapped_spi_flash.sv
// ============================================================================
//  Module      : mapped_spi_flash
//  Description : Read-only memory-mapped SPI NOR flash port for an RV32I bus.
//                A read strobe issues one serial READ (mode 0, SCLK = clk/2)
//                and returns one 32-bit little-endian word. mem_rbusy stays
//                high for the whole transaction.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   system clock, rising edge
//    reset      in   asynchronous active-high reset
//    mem_addr   in   byte address from the core, bits [1:0] ignored
//    mem_rstrb  in   read request, accepted only in IDLE
//    mem_rdata  out  last completed word, {byte3,byte2,byte1,byte0}
//    mem_rbusy  out  high while a transaction is in flight
//    spi_cs_n   out  flash chip select, active low
//    spi_clk    out  flash serial clock, idles low
//    spi_mosi   out  command/address, MSB first
//    spi_miso   in   data from flash
//  Build option
//    MAPPED_SPI_FAST_READ_EN : use FAST READ (0x0B) with 8 dummy bits,
//                              144-cycle transaction instead of 128.
// ============================================================================
`default_nettype none

module mapped_spi_flash #(
    parameter int          ADDR_WIDTH   = 24,
    parameter logic [23:0] FLASH_OFFSET = 24'h000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rstrb,
    output logic [31:0]           mem_rdata,
    output logic                  mem_rbusy,
    output logic                  spi_cs_n,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

`ifdef MAPPED_SPI_FAST_READ_EN
    localparam logic [7:0] CMD = 8'h0B;
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DUMMY, ST_RECV} state_t;
`else
    localparam logic [7:0] CMD = 8'h03;
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_RECV} state_t;
`endif

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] tx_q, tx_d;
    logic [30:0] rx_q, rx_d;
    logic [31:0] rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;

    logic [23:0] addr24;
    logic [23:0] flash_addr;
    logic [31:0] rx_word;

    // Word-align and fit the bus address to the 24-bit flash address space.
    generate
        if (ADDR_WIDTH >= 24) begin : g_addr_trunc
            logic unused_addr_bits;
            if (ADDR_WIDTH > 24) begin : g_addr_hi
                assign unused_addr_bits = ^{mem_addr[ADDR_WIDTH-1:24], mem_addr[1:0]};
            end else begin : g_addr_exact
                assign unused_addr_bits = ^mem_addr[1:0];
            end
            assign addr24 = {mem_addr[23:2], 2'b00};
        end else begin : g_addr_ext
            logic unused_addr_bits;
            assign unused_addr_bits = ^mem_addr[1:0];
            assign addr24 = {{(24-ADDR_WIDTH){1'b0}}, mem_addr[ADDR_WIDTH-1:2], 2'b00};
        end
    endgenerate

    // 24-bit addition wraps modulo 2^24 naturally.
    assign flash_addr = addr24 + FLASH_OFFSET;

    // Completed receive word: the first byte off the wire lands in [31:24].
    assign rx_word = {rx_q, spi_miso};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            phase_q   <= 1'b0;
            bit_cnt_q <= 5'd0;
            tx_q      <= 32'd0;
            rx_q      <= 31'd0;
            rdata_q   <= 32'd0;
            busy_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_rstrb) begin
                    tx_d      = {CMD, flash_addr};
                    mosi_d    = CMD[7];
                    state_d   = ST_SEND;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    bit_cnt_d = 5'd0;
                    phase_d   = 1'b0;
                end
            end
            default: begin
                if (!phase_q) begin
                    // End of phase 0: raise SCLK, flash samples MOSI.
                    phase_d = 1'b1;
                    sclk_d  = 1'b1;
                end else begin
                    // End of phase 1: drop SCLK, sample MISO, present next bit.
                    phase_d   = 1'b0;
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    case (state_q)
                        ST_SEND: begin
                            // Rotate rather than shift so every tx bit is consumed.
                            tx_d   = {tx_q[30:0], tx_q[31]};
                            mosi_d = tx_q[30];
                            if (bit_cnt_q == 5'd31) begin
                                mosi_d    = 1'b0;
                                bit_cnt_d = 5'd0;
`ifdef MAPPED_SPI_FAST_READ_EN
                                state_d   = ST_DUMMY;
`else
                                state_d   = ST_RECV;
`endif
                            end
                        end
`ifdef MAPPED_SPI_FAST_READ_EN
                        ST_DUMMY: begin
                            mosi_d = 1'b0;
                            if (bit_cnt_q == 5'd7) begin
                                bit_cnt_d = 5'd0;
                                state_d   = ST_RECV;
                            end
                        end
`endif
                        ST_RECV: begin
                            mosi_d = 1'b0;
                            rx_d   = {rx_q[29:0], spi_miso};
                            if (bit_cnt_q == 5'd31) begin
                                // Byte swap: flash streams ascending addresses.
                                rdata_d   = {rx_word[7:0], rx_word[15:8],
                                             rx_word[23:16], rx_word[31:24]};
                                busy_d    = 1'b0;
                                cs_n_d    = 1'b1;
                                bit_cnt_d = 5'd0;
                                state_d   = ST_IDLE;
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
        endcase
    end

    assign mem_rdata = rdata_q;
    assign mem_rbusy = busy_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_clk   = sclk_q;
    assign spi_mosi  = mosi_q;

endmodule

`default_nettype wire
